md_unit_ctrl: RTL and testbench
===============================

Name: md_unit_ctrl

Overview:
- Multi-cycle multiply/divide sequencer for the pipelined MIPS core, sitting in the E stage beside the ALU.
- Takes a one-cycle start from the E-stage decode, holds the operands and counts out the mult/div latency.
- Commits results to the architectural HI/LO registers.
- Raises a stall to the hazard logic while a D-stage instruction needs the unit.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1).
- DIV_CYCLES, 10, busy cycles for div/divu (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  E-stage MD instruction valid this cycle.
- md_op  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, others no-op.
- rs_val  input  32  forwarded GPR[rs] (dividend / multiplicand / mthi-mtlo source).
- rt_val  input  32  forwarded GPR[rt] (divisor / multiplier).
- md_use_d  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- busy  output  1  operation in flight.
- stall  output  1  freeze PC/IF-ID, bubble into E.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- One clock domain (clk); reset is synchronous, active-high. While reset=1 at a rising edge: state=IDLE, counter=0, hi=0, lo=0, busy=0, pending result cleared.
- Three states: IDLE, MULT, DIV. A 4-bit-or-wider down-counter sized for max(MULT_CYCLES, DIV_CYCLES).
- IDLE with start=1 at edge T:
  - op 000/001: latch 64-bit product into pending {hi,lo}; load counter=MULT_CYCLES; go to MULT.
  - op 010/011: latch quotient→pending lo and remainder→pending hi; load counter=DIV_CYCLES; go to DIV.
  - op 100/101: write rs_val to hi/lo at edge T; stay IDLE; busy never asserts.
  - Other op codes: no effect.
- MULT/DIV: counter decrements each edge. When the counter reaches 1, that edge commits pending to hi/lo and returns to IDLE.
- Timing: busy is high exactly N cycles, T+1..T+N. New hi/lo are visible from cycle T+N+1.
- busy is registered: 1 iff state≠IDLE.
- stall is combinational: md_use_d & (start | busy). mfhi/mflo in D is therefore stalled until results are committed.
- start while busy (should not occur due to stall) is ignored; the in-flight operation is unaffected.
- Arithmetic:
  - mult: signed 32×32→64. multu: unsigned.
  - div/divu: quotient truncates toward zero; remainder takes the sign of the dividend.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divisor 0: the op still runs DIV_CYCLES busy, but hi/lo are left unchanged at commit.
- Reset mid-operation: the pending result is discarded, outputs take reset values, and the next start is accepted normally.
- hi/lo change only on commit, mthi/mtlo, or reset.

Test Plan:
- Reset, then mult rs=0xFFFFFFFE (−2), rt=3 → busy high cycles T+1..T+5; hi=0xFFFFFFFF, lo=0xFFFFFFFA at T+6; hi/lo unchanged during T+1..T+5.
- multu rs=0xFFFFFFFF, rt=2 → hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
- div rs=0xFFFFFFF9 (−7), rt=2 → after 10 busy cycles lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). divu with the same operands → lo=0x7FFFFFFC, hi=1.
- mthi rs=0x12345678, then mtlo rs=0x9ABCDEF0 on consecutive cycles → hi/lo updated the next edge each; busy stays 0; stall only when md_use_d coincides with start.
- div with rt=0 after hi=0xAAAA0000, lo=0x5555 → busy 10 cycles, hi/lo unchanged. Then mult started with md_use_d=1 held → stall=1 for cycle T and T+1..T+5, 0 at T+6.
- Start div, assert reset at cycle T+4 → next cycle busy=0, hi=lo=0. Then a fresh mult 6×7 → lo=42, hi=0 after 5 cycles.

Source files
------------

// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer for the E stage: latches the result at start,
// counts out the unit latency, then commits to the architectural HI/LO.
module md_unit_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_use_d,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = ($clog2(MAX_CYC + 1) < 4) ? 4 : $clog2(MAX_CYC + 1);

    typedef enum logic [1:0] {IDLE, MULT, DIV} state_t;

    state_t        state, stateNext;
    logic [CW-1:0] count, countNext;
    logic [31:0]   pendHi, pendLo;
    logic          pendValid;
    logic          latchMult, latchDiv, commit, writeHi, writeLo;

    // Arithmetic is evaluated on the start cycle; only the result is held.
    logic        isSigned;
    logic [63:0] opA64, opB64, product;
    logic [31:0] absA, absB, divisor, quoMag, remMag, quotient, remainder;

    always_comb begin
        isSigned = ~md_op[0];
        opA64    = {(isSigned && rs_val[31]) ? 32'hFFFF_FFFF : 32'h0, rs_val};
        opB64    = {(isSigned && rt_val[31]) ? 32'hFFFF_FFFF : 32'h0, rt_val};
        product  = opA64 * opB64;

        // Sign-magnitude division; 0x80000000 / -1 falls out as 0x80000000 rem 0.
        absA      = (isSigned && rs_val[31]) ? -rs_val : rs_val;
        absB      = (isSigned && rt_val[31]) ? -rt_val : rt_val;
        divisor   = (absB == 32'h0) ? 32'h1 : absB;
        quoMag    = absA / divisor;
        remMag    = absA % divisor;
        quotient  = (isSigned && (rs_val[31] ^ rt_val[31])) ? -quoMag : quoMag;
        remainder = (isSigned && rs_val[31]) ? -remMag : remMag;
    end

    always_comb begin
        stateNext = state;
        countNext = count;
        latchMult = 1'b0;
        latchDiv  = 1'b0;
        commit    = 1'b0;
        writeHi   = 1'b0;
        writeLo   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    case (md_op)
                        3'b000, 3'b001: begin
                            latchMult = 1'b1;
                            countNext = CW'(MULT_CYCLES);
                            stateNext = MULT;
                        end
                        3'b010, 3'b011: begin
                            latchDiv  = 1'b1;
                            countNext = CW'(DIV_CYCLES);
                            stateNext = DIV;
                        end
                        3'b100:  writeHi = 1'b1;
                        3'b101:  writeLo = 1'b1;
                        default: ;
                    endcase
                end
            end
            MULT, DIV: begin
                if (count == CW'(1)) begin
                    commit    = 1'b1;
                    countNext = '0;
                    stateNext = IDLE;
                end else begin
                    countNext = count - CW'(1);
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            pendHi    <= '0;
            pendLo    <= '0;
            pendValid <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            state <= stateNext;
            count <= countNext;
            if (latchMult) begin
                {pendHi, pendLo} <= product;
                pendValid        <= 1'b1;
            end
            if (latchDiv) begin
                pendHi    <= remainder;
                pendLo    <= quotient;
                pendValid <= (rt_val != 32'h0);
            end
            // Divide-by-zero still burns its cycles but leaves HI/LO alone.
            if (commit && pendValid) begin
                hi <= pendHi;
                lo <= pendLo;
            end
            if (writeHi) hi <= rs_val;
            if (writeLo) lo <= rs_val;
        end
    end

    assign busy  = (state != IDLE);
    assign stall = md_use_d & (start | busy);
endmodule

// File: tb/tb_md_unit_ctrl.sv
// Scoreboard bench for md_unit_ctrl: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares busy/stall/hi/lo.
module tb_md_unit_ctrl;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset, start, md_use_d;
    logic [2:0]  md_op;
    logic [31:0] rs_val, rt_val;
    logic        busy, stall;
    logic [31:0] hi, lo;

    md_unit_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .rs_val(rs_val), .rt_val(rt_val), .md_use_d(md_use_d),
        .busy(busy), .stall(stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        eBusy;
        logic        eStall;
        logic [31:0] eHi;
        logic [31:0] eLo;
    } exp_t;

    exp_t expQ[$];
    exp_t cur;
    int   nChecks = 0;
    int   nFail   = 0;

    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            cur = expQ.pop_front();
            nChecks++;
            if (busy !== cur.eBusy) begin
                nFail++;
                $display("FAIL %s busy: got %0b want %0b", cur.name, busy, cur.eBusy);
            end
            nChecks++;
            if (stall !== cur.eStall) begin
                nFail++;
                $display("FAIL %s stall: got %0b want %0b", cur.name, stall, cur.eStall);
            end
            nChecks++;
            if (hi !== cur.eHi) begin
                nFail++;
                $display("FAIL %s hi: got %h want %h", cur.name, hi, cur.eHi);
            end
            nChecks++;
            if (lo !== cur.eLo) begin
                nFail++;
                $display("FAIL %s lo: got %h want %h", cur.name, lo, cur.eLo);
            end
        end
    end

    // Drive one cycle of inputs and queue what the outputs must show in it.
    task automatic cyc(input logic rst, input logic st, input logic [2:0] op,
                       input logic [31:0] rs, input logic [31:0] rt, input logic use_d,
                       input logic eb, input logic es, input logic [31:0] eh,
                       input logic [31:0] el, input string nm);
        exp_t e;
        reset = rst; start = st; md_op = op; rs_val = rs; rt_val = rt; md_use_d = use_d;
        e.name = nm; e.eBusy = eb; e.eStall = es; e.eHi = eh; e.eLo = el;
        expQ.push_back(e);
        @(posedge clk); #1;
    endtask

    // Start cycle, n busy cycles with old HI/LO, then the committed values.
    // poke=1 fires an mthi during the busy window, which must be ignored.
    task automatic runOp(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic use_d, input int n, input logic poke,
                         input logic [31:0] oh, input logic [31:0] ol,
                         input logic [31:0] nh, input logic [31:0] nl, input string nm);
        cyc(1'b0, 1'b1, op, rs, rt, use_d, 1'b0, use_d, oh, ol, {nm, "_start"});
        for (int i = 0; i < n; i++)
            cyc(1'b0, poke, 3'b100, 32'hDEAD_BEEF, 32'h0, use_d, 1'b1, use_d, oh, ol, {nm, "_busy"});
        cyc(1'b0, 1'b0, 3'b111, 32'h0, 32'h0, use_d, 1'b0, 1'b0, nh, nl, {nm, "_done"});
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; md_op = 3'b111; rs_val = '0; rt_val = '0; md_use_d = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc(1'b0, 1'b0, 3'b111, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, "reset_state");

        runOp(3'b000, 32'hFFFF_FFFE, 32'd3, 1'b0, MC, 1'b0,
              32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult_neg");
        runOp(3'b001, 32'hFFFF_FFFF, 32'd2, 1'b0, MC, 1'b1,
              32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'h0000_0001, 32'hFFFF_FFFE, "multu_poke");
        runOp(3'b010, 32'hFFFF_FFF9, 32'd2, 1'b0, DC, 1'b0,
              32'h0000_0001, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
        runOp(3'b011, 32'hFFFF_FFF9, 32'd2, 1'b0, DC, 1'b0,
              32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0000_0001, 32'h7FFF_FFFC, "divu");
        runOp(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, DC, 1'b0,
              32'h0000_0001, 32'h7FFF_FFFC, 32'h0, 32'h8000_0000, "div_ovf");

        cyc(1'b0, 1'b1, 3'b100, 32'h1234_5678, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h8000_0000, "mthi");
        cyc(1'b0, 1'b1, 3'b101, 32'h9ABC_DEF0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 32'h8000_0000, "mtlo");
        cyc(1'b0, 1'b0, 3'b111, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, "mt_done");

        cyc(1'b0, 1'b1, 3'b100, 32'hAAAA_0000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, "mthi2");
        cyc(1'b0, 1'b1, 3'b101, 32'h0000_5555, 32'h0, 1'b0, 1'b0, 1'b0, 32'hAAAA_0000, 32'h9ABC_DEF0, "mtlo2");
        runOp(3'b010, 32'd1234, 32'h0, 1'b0, DC, 1'b0,
              32'hAAAA_0000, 32'h0000_5555, 32'hAAAA_0000, 32'h0000_5555, "div_zero");

        runOp(3'b000, 32'h0001_0000, 32'h0001_0000, 1'b1, MC, 1'b0,
              32'hAAAA_0000, 32'h0000_5555, 32'h0000_0001, 32'h0, "mult_stall");

        cyc(1'b0, 1'b1, 3'b110, 32'h5, 32'h6, 1'b1, 1'b0, 1'b1, 32'h1, 32'h0, "noop_start");
        cyc(1'b0, 1'b0, 3'b111, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h1, 32'h0, "noop_after");

        cyc(1'b0, 1'b1, 3'b010, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0, 32'h1, 32'h0, "rst_div_start");
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b0, 3'b111, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h1, 32'h0, "rst_div_busy");
        cyc(1'b1, 1'b0, 3'b111, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h1, 32'h0, "rst_assert");
        cyc(1'b0, 1'b0, 3'b111, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, "rst_after");
        runOp(3'b000, 32'd6, 32'd7, 1'b0, MC, 1'b0,
              32'h0, 32'h0, 32'h0, 32'd42, "mult_after_rst");

        for (int i = 0; i < 20 && expQ.size() > 0; i++) @(posedge clk);
        if (expQ.size() > 0) begin
            nFail++;
            $display("FAIL drain: %0d expectations left, want 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
